// File: rtl/nf_ahb_slave_bridge.sv
// nf_ahb_slave_bridge
// AHB-Lite responder for one slave lane of the router. Each accepted AHB
// transfer becomes a single req/ack access on a simple peripheral bus.
// Illegal transfers get a two-cycle ERROR response, and a peripheral that
// never acknowledges is timed out with the same ERROR response.
//
// Handshakes:
//   AHB side: the address phase is accepted when hready_s & hsel_s &
//   htrans_s[1]. A data phase completes in the cycle hready_s=1.
//   Peripheral side: p_req stays high from the cycle after acceptance until
//   the cycle p_ack=1 (one-cycle pulse) or the timeout expires. p_addr,
//   p_size and p_we are stable while p_req=1.
//
// Ports:
//   hclk, hresetn          clock, async active-low reset
//   haddr_s .. hsel_s      AHB-Lite slave-side signals from/to the router
//   p_addr, p_wd, p_we,
//   p_size, p_req          peripheral request outputs
//   p_ack, p_rd            peripheral acknowledge and read data
//   state_dbg              current FSM state (0 IDLE, 1 DATA, 2 ERR1, 3 ERR2)
module nf_ahb_slave_bridge #(
  parameter int timeout_c = 16
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] haddr_s,
  input  logic [31:0] hwdata_s,
  output logic [31:0] hrdata_s,
  input  logic        hwrite_s,
  input  logic [1:0]  htrans_s,
  input  logic [2:0]  hsize_s,
  input  logic [2:0]  hburst_s,
  output logic [1:0]  hresp_s,
  output logic        hready_s,
  input  logic        hsel_s,
  output logic [31:0] p_addr,
  output logic [31:0] p_wd,
  output logic        p_we,
  output logic [1:0]  p_size,
  output logic        p_req,
  input  logic        p_ack,
  input  logic [31:0] p_rd,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  // Counter value seen in the last allowed ack-less DATA cycle.
  localparam logic [7:0] TMO_LAST = 8'(timeout_c - 1);

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic        we_q;
  logic [31:0] rdata_q;

  logic accept;
  logic legal;
  logic ack_data;
  logic timed_out;

  // Bursts are treated beat by beat; the burst type and BUSY/IDLE
  // distinction carry no information for this bridge.
  logic unused_inputs;
  assign unused_inputs = ^{hburst_s, htrans_s[0]};

  always_comb begin
    hready_s = 1'b1;
    hresp_s  = 2'b00;
    case (state)
      ST_DATA: hready_s = p_ack;
      ST_ERR1: begin
        hready_s = 1'b0;
        hresp_s  = 2'b01;
      end
      ST_ERR2: hresp_s = 2'b01;
      default: ;
    endcase

    accept    = hready_s & hsel_s & htrans_s[1];
    legal     = (hsize_s == 3'b000) ||
                (hsize_s == 3'b001 && !haddr_s[0]) ||
                (hsize_s == 3'b010 && haddr_s[1:0] == 2'b00);
    ack_data  = (state == ST_DATA) & p_ack;
    timed_out = (state == ST_DATA) & !p_ack & (tmo_cnt == TMO_LAST);

    // Bypass so a read returns data in its completion cycle.
    hrdata_s  = (ack_data && !we_q) ? p_rd : rdata_q;
  end

  assign p_wd      = hwdata_s;
  assign p_we      = p_req & we_q;
  assign state_dbg = state;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state   <= ST_IDLE;
      tmo_cnt <= 8'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
      p_addr  <= 32'd0;
      p_size  <= 2'd0;
      p_req   <= 1'b0;
    end else begin
      if (accept) begin
        p_addr <= haddr_s;
        we_q   <= hwrite_s;
        p_size <= hsize_s[1:0];
      end

      if (ack_data && !we_q) begin
        rdata_q <= p_rd;
      end

      case (state)
        ST_IDLE, ST_ERR2: begin
          tmo_cnt <= 8'd0;
          if (accept && legal) begin
            state <= ST_DATA;
            p_req <= 1'b1;
          end else if (accept) begin
            state <= ST_ERR1;
            p_req <= 1'b0;
          end else begin
            state <= ST_IDLE;
            p_req <= 1'b0;
          end
        end
        ST_DATA: begin
          if (p_ack) begin
            // Completion cycle doubles as the next address phase.
            tmo_cnt <= 8'd0;
            if (accept && legal) begin
              state <= ST_DATA;
              p_req <= 1'b1;
            end else if (accept) begin
              state <= ST_ERR1;
              p_req <= 1'b0;
            end else begin
              state <= ST_IDLE;
              p_req <= 1'b0;
            end
          end else if (timed_out) begin
            tmo_cnt <= 8'd0;
            state   <= ST_ERR1;
            p_req   <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        ST_ERR1: begin
          state <= ST_ERR2;
          p_req <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/nf_ahb_slave_bridge.md
# nf_ahb_slave_bridge

AHB-Lite responder that terminates one slave port of the AHB router (one `hsel_s` lane plus its `h*_s` signals) and converts each accepted transfer into a single request/acknowledge access on a simple peripheral bus. It provides the slave-side `hready_s`/`hresp_s`/`hrdata_s` that the router multiplexes back to the master. It also inserts wait states, rejects illegal transfers with a two-cycle ERROR response, and times out peripherals that never acknowledge.

## Interface
- `timeout_c`, default 16: maximum number of request cycles without `ack` before an ERROR response; legal range 2..255.
- `hclk`  input  1  system clock, all state on rising edge.
- `hresetn`  input  1  reset, asynchronous, active-low.
- `haddr_s`  input  32  AHB address from router.
- `hwdata_s`  input  32  AHB write data, valid in the data phase.
- `hrdata_s`  output  32  AHB read data to router.
- `hwrite_s`  input  1  1 = write.
- `htrans_s`  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `hsize_s`  input  3  000 byte, 001 half, 010 word; others illegal.
- `hburst_s`  input  3  ignored; every beat is handled as a single transfer.
- `hresp_s`  output  2  00 OKAY, 01 ERROR.
- `hready_s`  output  1  transfer-done / bridge-ready.
- `hsel_s`  input  1  slave select from router decoder.
- `p_addr`  output  32  peripheral address, registered.
- `p_wd`  output  32  peripheral write data.
- `p_we`  output  1  peripheral write enable, qualified by `p_req`.
- `p_size`  output  2  peripheral access size, `hsize_s[1:0]` captured.
- `p_req`  output  1  peripheral request, registered.
- `p_ack`  input  1  peripheral acknowledge; one-cycle pulse per request.
- `p_rd`  input  32  peripheral read data, valid when `p_ack`=1.

## Operation
- **Address-phase acceptance.** An address phase is accepted in a cycle where `hready_s`=1, `hsel_s`=1 and `htrans_s[1]`=1 (NONSEQ or SEQ).
  - On acceptance, `haddr_s`, `hwrite_s` and `hsize_s` are registered.
  - IDLE and BUSY transfers, or transfers with `hsel_s`=0, are never accepted. The bridge returns a zero-wait OKAY for them.
- **Legality.** A transfer is illegal if:
  - `hsize_s` > 010, or
  - `hsize_s`=001 and `haddr_s[0]`=1, or
  - `hsize_s`=010 and `haddr_s[1:0]`≠00.
- **FSM states:** IDLE, DATA, ERR1, ERR2.
  - **IDLE:** `hready_s`=1, `hresp_s`=OKAY, `p_req`=0.
    - Legal accept → DATA.
    - Illegal accept → ERR1.
  - **DATA:** `p_req`=1 with the captured address, size and `p_we`=captured `hwrite_s`. `p_wd` is driven directly from `hwdata_s`.
    - `hready_s` = `p_ack` (combinational) and `hresp_s`=OKAY.
    - On `p_ack`=1 the beat completes and `p_req` drops on the next edge. Next state: DATA again if a legal accept occurs in the same cycle, ERR1 if an illegal accept occurs, otherwise IDLE.
    - With `p_ack`=0, the timeout counter increments. Once `timeout_c` consecutive DATA cycles pass without `p_ack` → ERR1, and `p_req` drops.
  - **ERR1:** `hready_s`=0, `hresp_s`=ERROR, `p_req`=0 → ERR2.
  - **ERR2:** `hready_s`=1, `hresp_s`=ERROR. Next state: DATA on a legal accept, ERR1 on an illegal accept, otherwise IDLE.
- **Timeout counter.** 8 bits wide. Cleared on every entry to DATA and on `p_ack`.
- **Read data.** `hrdata_s` is a register loaded from `p_rd` on a read completion (`p_ack`=1 with captured `hwrite_s`=0). The register value is shown on the bus as follows:
  - In the completion cycle, `hrdata_s` = `p_rd` (bypass mux).
  - Otherwise `hrdata_s` holds the last read value.
  - Writes never change it.
- **Late ack.** A `p_ack` arriving outside DATA is ignored.

## Timing
- **Reset values** (asynchronous on `hresetn`=0):
  - state=IDLE, `hready_s`=1, `hresp_s`=00, `hrdata_s`=0.
  - `p_req`=0, `p_we`=0, `p_addr`=0, `p_size`=0, counter=0.
- **Reset mid-transfer:** aborts immediately to the reset values. No ack or ERROR is issued afterwards.
- **Minimum latency:** address phase at cycle N; `p_req`=1 at cycle N+1.
  - If `p_ack`=1 in N+1, the beat completes zero-wait in N+1.
  - Each ack-less cycle adds one wait state.
- **Back-to-back pipelined transfers:** sustain one beat per cycle when `p_ack` is held high. `p_req` stays high across beats, and `p_addr` updates on each accept.
- **ERROR response:** always exactly two cycles, ERR1 followed by ERR2. A timeout completes at cycle N+1+`timeout_c` (ERR1) and N+2+`timeout_c` (ERR2).
- **Data-phase sampling:** `hwdata_s` must be stable during every DATA cycle. The bridge does not register it.

## Test plan
- **Reset values:** assert `hresetn`=0 mid-DATA → all outputs at their reset values within the same cycle, with no clock edge needed. Deassert → IDLE, `hready_s`=1.
- **Zero-wait word write:** NONSEQ write to 0x0000_1004, size 010, `hwdata_s`=0xDEADBEEF, `p_ack` tied high.
  - N+1: `p_req`=1, `p_we`=1, `p_addr`=0x1004, `p_wd`=0xDEADBEEF, `hready_s`=1, OKAY.
- **Wait-state read:** read of 0x2000 with `p_ack` after 3 cycles and `p_rd`=0x12345678.
  - `hready_s`=0 for 3 cycles, then 1 with `hrdata_s`=0x12345678, OKAY.
  - `hrdata_s` stays 0x12345678 afterwards.
- **Illegal transfers:** (a) half-word at 0x3001, (b) `hsize_s`=011.
  - Each gives `p_req` never asserted, then `hready_s`/`hresp_s` = 0/01 followed by 1/01, then IDLE.
- **Timeout:** `timeout_c`=4, `p_ack` held low.
  - `p_req` high for 4 cycles, then ERR1/ERR2. A late `p_ack` one cycle later is ignored.
- **Pipelined burst:** 4 SEQ write beats at 0x100/104/108/10C with `p_ack` high → 4 consecutive completions, `p_addr` stepping by 4 each cycle, and a return to IDLE on the trailing IDLE htrans.
- **Ignored selects:** IDLE, BUSY and `hsel_s`=0 cycles interleaved → no `p_req`, and `hready_s`=1 with OKAY throughout.
